multiplicador: RTL and testbench
================================

# multiplicador

Sequential shift-and-add multiply-accumulate unit, the inverse of the `divisor` block: it takes a quotient, divisor and remainder and reconstructs the dividend as P = Q·D + R. It also flags whether the triple is a valid division result. It sits next to `divisor` on the same clock, closing the loop for self-checking and for display of the reconstructed operand.

## Interface
Parameters:
- `N`, default 4: operand width; the product/result width is 2N.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; when low, forces IDLE and clears all registers.
- `start`  in  1  request; sampled only in IDLE.
- `Q`  in  N  multiplier (quotient).
- `D`  in  N  multiplicand (divisor).
- `R`  in  N  addend (remainder).
- `P`  out  2N  result Q·D + R; holds its value until the next completion.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion strobe.
- `valido`  out  1  qualifies `done`: 1 when D ≠ 0 and R < D; holds its value with P.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, with `start` = 1 at an edge:
  - latch acc ← zero-extended R, mcand ← zero-extended D (2N bits), mplier ← Q, cnt ← N;
  - compute the validity bit from the latched D and R and hold it internally;
  - go to RUN.
- IDLE, with `start` = 0: stay in IDLE.
- RUN, each edge:
  - if mplier[0] = 1, acc ← acc + mcand (2N-bit add);
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt − 1.
- RUN, on the edge where cnt goes 1 → 0:
  - P ← final acc, `valido` ← latched validity bit;
  - go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE unconditionally.
- Width rule: the maximum result is (2^N−1)² + (2^N−1) = 2^2N − 2^N, so the 2N-bit result never overflows. No carry-out is needed.
- Operands are captured at start. Changes on Q/D/R while busy do not affect the result.
- `start` in RUN or DONE is ignored, not queued. `start` held high continuously gives back-to-back operations with one IDLE cycle between them.
- D = 0: P = R, `valido` = 0.
- Q = 0: P = R, with zero additions.
- Reset low at any time, including mid-RUN: state → IDLE; P, acc, mcand, mplier, cnt, `valido`, `done`, `busy` all → 0. The operation in progress is lost.

## Timing
- Reset values: P = 0, `done` = 0, `busy` = 0, `valido` = 0, state = IDLE.
- `start` sampled high at edge k:
  - `busy` is high from edge k to edge k+N+1;
  - P and `valido` update at edge k+N;
  - `done` is high for the cycle between edges k+N and k+N+1.
- Latency: N+1 cycles from start edge to return to IDLE; a new start can be sampled at edge k+N+2 at the earliest.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- `done` and `valido` are coincident. Consumers sample P when `done` = 1.

## Structure
- Shared header `multiplicador_defs.vh`, also used by `divisor`:
  - state encoding localparams S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  - default width N = 4.
- Encoding 2'd3 is illegal and recovers to IDLE on the next edge.
- One natural sub-module: `sumador`, a 2N-bit combinational adder for acc + mcand, reusable by `divisor`'s restoring subtract path.
- Everything else (FSM, shift registers, counter, output registers) is in `multiplicador`.

## Test plan
- Q=5, D=3, R=0, start pulse → `done` at start edge + 4 with P=15, `valido`=1, `busy` high 5 cycles.
- Q=3, D=4, R=3 → P=15, `valido`=1; a second start with Q=15, D=15, R=15 → P=240, `valido`=0 (R ≥ D).
- Q=7, D=0, R=5 → P=5, `valido`=0; Q=0, D=9, R=2 → P=2, `valido`=1.
- Start Q=2, D=6, R=1, then pulse `start` and change Q=15 on the 2nd RUN cycle → single `done`, P=13; the second start produces no extra `done`.
- Start Q=15, D=15, R=0, assert reset low during the 3rd RUN cycle → P=0, `busy`=0, `done`=0 immediately (asynchronous). After release, a new start Q=4, D=4, R=1 → P=17, `valido`=1.
- `start` held high for 20 cycles with Q=1, D=2, R=1 → `done` every 6 cycles, P=3 each time.

Source files
------------

// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the shift-and-add multiply-accumulate unit.
package multiplicador_pkg;

    // Default operand width; the result is twice this wide.
    localparam int unsigned DefaultWidth = 4;

    // Encoding is shared with the companion divider; 2'd3 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/multiplicador_if.sv
// Operand/result bundle between a requester and the multiply-accumulate unit.
interface multiplicador_if
    import multiplicador_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) ();

    logic           start;
    logic [N-1:0]   Q;
    logic [N-1:0]   D;
    logic [N-1:0]   R;
    logic [2*N-1:0] P;
    logic           busy;
    logic           done;
    logic           valido;

    modport master (
        output start, Q, D, R,
        input  P, busy, done, valido
    );

    modport slave (
        input  start, Q, D, R,
        output P, busy, done, valido
    );

endinterface

// File: rtl/multiplicador_sumador.sv
// Plain combinational adder; the carry-out is dropped because the accumulated
// result Q*D + R always fits in the full width.
module multiplicador_sumador #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    // Width-preserving add.
    always_comb begin
        sum_o = a_i + b_i;
    end

endmodule

// File: rtl/multiplicador.sv
// Sequential shift-and-add multiply-accumulate: P = Q*D + R, one multiplier bit per cycle.
// Also flags whether (Q, D, R) is a legal division result (D != 0 and R < D).
module multiplicador
    import multiplicador_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) (
    input  logic              clk,
    input  logic              reset,
    multiplicador_if.slave    bus
);

    localparam int unsigned W    = 2 * N;
    localparam int unsigned CntW = $clog2(N + 1);

    state_e          state_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    mcand_q;
    logic [N-1:0]    mplier_q;
    logic [CntW-1:0] cnt_q;
    logic            valid_q;
    logic [W-1:0]    p_q;
    logic            valido_q;
    logic            busy_q;
    logic            done_q;

    logic [W-1:0]    acc_sum;
    logic [W-1:0]    acc_d;

    multiplicador_sumador #(
        .W (W)
    ) u_sumador (
        .a_i   (acc_q),
        .b_i   (mcand_q),
        .sum_o (acc_sum)
    );

    // Add the shifted multiplicand only when the current multiplier bit is set.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_sum;
        end
    end

    // FSM, datapath registers and registered outputs in one process.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            p_q      <= '0;
            valido_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        acc_q    <= {{N{1'b0}}, bus.R};
                        mcand_q  <= {{N{1'b0}}, bus.D};
                        mplier_q <= bus.Q;
                        cnt_q    <= CntW'(N);
                        valid_q  <= (bus.D != '0) && (bus.R < bus.D);
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                StRun: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CntW'(1);
                    busy_q   <= 1'b1;
                    // Last multiplier bit: publish the result and validity together.
                    if (cnt_q == CntW'(1)) begin
                        p_q      <= acc_d;
                        valido_q <= valid_q;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // Start is not sampled here, which enforces one idle cycle between jobs.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.P      = p_q;
    assign bus.valido = valido_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_multiplicador.sv
// Directed bench for the multiply-accumulate unit with hand-computed results.
module tb_multiplicador;

    localparam int unsigned N = 4;

    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    multiplicador_if #(.N(N)) bus_if ();

    multiplicador #(
        .N (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One start pulse; checks latency, busy length and the result.
    task automatic run_op(input string tag, input int q, input int d, input int r,
                          input int exp_p, input int exp_v);
        int cyc;
        int busy_cnt;
        bit got_done;
        bus_if.Q     = q[N-1:0];
        bus_if.D     = d[N-1:0];
        bus_if.R     = r[N-1:0];
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        check_val({tag, "_busy_start"}, int'(bus_if.busy), 1);
        busy_cnt = 1;
        cyc      = 0;
        got_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            cyc++;
            if (bus_if.busy) busy_cnt++;
            if (bus_if.done) begin
                got_done = 1'b1;
                break;
            end
        end
        check_val({tag, "_done_seen"}, int'(got_done), 1);
        check_val({tag, "_latency"}, cyc, N);
        check_val({tag, "_P"}, int'(bus_if.P), exp_p);
        check_val({tag, "_valido"}, int'(bus_if.valido), exp_v);
        step();
        check_val({tag, "_done_one_cycle"}, int'(bus_if.done), 0);
        check_val({tag, "_busy_cycles"}, busy_cnt, N + 1);
        check_val({tag, "_busy_low"}, int'(bus_if.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        int last_edge;
        bit idle_seen;
        n_tests = 0;
        n_fail  = 0;
        reset        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.Q     = '0;
        bus_if.D     = '0;
        bus_if.R     = '0;
        step();
        step();
        check_val("rst_P", int'(bus_if.P), 0);
        check_val("rst_busy", int'(bus_if.busy), 0);
        check_val("rst_done", int'(bus_if.done), 0);
        check_val("rst_valido", int'(bus_if.valido), 0);
        reset = 1'b1;
        step();

        run_op("t1", 5, 3, 0, 15, 1);
        run_op("t2a", 3, 4, 3, 15, 1);
        run_op("t2b", 15, 15, 15, 240, 0);
        run_op("t3a", 7, 0, 5, 5, 0);
        run_op("t3b", 0, 9, 2, 2, 1);

        // Operand change and a second start while running must be ignored.
        bus_if.Q = 4'd2; bus_if.D = 4'd6; bus_if.R = 4'd1;
        bus_if.start = 1'b1;
        step();                       // start edge k
        bus_if.start = 1'b0;
        step();                       // edge k+1
        bus_if.start = 1'b1;
        bus_if.Q     = 4'd15;
        step();                       // edge k+2, start ignored in RUN
        bus_if.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus_if.done) begin
                dones++;
                check_val("t4_P", int'(bus_if.P), 13);
            end
        end
        check_val("t4_done_count", dones, 1);
        check_val("t4_busy_low", int'(bus_if.busy), 0);

        // Asynchronous reset in the third RUN cycle.
        bus_if.Q = 4'd15; bus_if.D = 4'd15; bus_if.R = 4'd0;
        bus_if.start = 1'b1;
        step();                       // start edge k
        bus_if.start = 1'b0;
        step();                       // edge k+1
        step();                       // edge k+2, third RUN cycle begins
        #2;
        reset = 1'b0;
        #1;
        check_val("t5_rst_P", int'(bus_if.P), 0);
        check_val("t5_rst_busy", int'(bus_if.busy), 0);
        check_val("t5_rst_done", int'(bus_if.done), 0);
        step();
        reset = 1'b1;
        step();
        check_val("t5_idle_busy", int'(bus_if.busy), 0);
        run_op("t5b", 4, 4, 1, 17, 1);

        // Start held high: a job every N+2 cycles.
        bus_if.Q = 4'd1; bus_if.D = 4'd2; bus_if.R = 4'd1;
        bus_if.start = 1'b1;
        dones     = 0;
        last_edge = -1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (bus_if.done) begin
                dones++;
                check_val("t6_P", int'(bus_if.P), 3);
                if (last_edge >= 0) check_val("t6_period", e - last_edge, N + 2);
                else check_val("t6_first_done", e, N + 1);
                last_edge = e;
            end
        end
        check_val("t6_done_count", dones, 3);
        bus_if.start = 1'b0;
        idle_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!bus_if.busy) begin
                idle_seen = 1'b1;
                break;
            end
        end
        check_val("t6_returns_idle", int'(idle_seen), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
